// File: rtl/park_transform.sv
// park_transform: forward Park transform (alpha/beta -> D/Q) with a single
// shared multiplier stepped through four accumulate cycles.
//   D = (alpha*cos + beta*sin) >>> Q_BITS
//   Q = (beta*cos - alpha*sin) >>> Q_BITS
// Optional build macro PARK_SAT_EN: clamp results to the D_WIDTH signed range
// and flag the clamp on sat. Without it results wrap and sat stays 0.
module park_transform #(
  parameter int D_WIDTH = 32,
  parameter int Q_BITS  = 10
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [D_WIDTH-1:0] alpha,
  input  logic [D_WIDTH-1:0] beta,
  input  logic [D_WIDTH-1:0] sin,
  input  logic [D_WIDTH-1:0] cos,
  input  logic               start,
  output logic               busy,
  output logic [D_WIDTH-1:0] d,
  output logic [D_WIDTH-1:0] q,
  output logic               done,
  output logic               sat
);

  localparam int P_W   = 2 * D_WIDTH;
  localparam int ACC_W = 2 * D_WIDTH + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] M_AC = 3'd1;
  localparam logic [2:0] M_BS = 3'd2;
  localparam logic [2:0] M_BC = 3'd3;
  localparam logic [2:0] M_AS = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  logic [2:0]                state_q, state_d;
  logic signed [D_WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, c_q, c_d;
  logic signed [ACC_W-1:0]   dacc_q, dacc_d, qacc_q, qacc_d;
  logic [D_WIDTH-1:0]        d_q, d_d, q_q, q_d;
  logic                      done_q, done_d;
  logic                      sat_q, sat_d;

  logic signed [D_WIDTH-1:0] mul_x, mul_y;
  logic signed [P_W-1:0]     mul_xe, mul_ye, prod;
  logic signed [ACC_W-1:0]   prod_ext;

  logic signed [ACC_W-1:0]   d_shift, q_shift;
  logic [D_WIDTH-1:0]        d_res, q_res;
  logic                      d_clamp, q_clamp;

  // Route the latched operand pair for the current accumulate step to the multiplier
  always_comb begin
    mul_x = a_q;
    mul_y = c_q;
    case (state_q)
      M_BS: begin
        mul_x = b_q;
        mul_y = s_q;
      end
      M_BC: begin
        mul_x = b_q;
        mul_y = c_q;
      end
      M_AS: begin
        mul_x = a_q;
        mul_y = s_q;
      end
      default: begin
        mul_x = a_q;
        mul_y = c_q;
      end
    endcase
  end

  // Full-precision signed product; the 2W-bit result cannot overflow
  assign mul_xe   = {{D_WIDTH{mul_x[D_WIDTH-1]}}, mul_x};
  assign mul_ye   = {{D_WIDTH{mul_y[D_WIDTH-1]}}, mul_y};
  assign prod     = mul_xe * mul_ye;
  assign prod_ext = {prod[P_W-1], prod};

  // Arithmetic shift floors toward -inf
  assign d_shift = dacc_q >>> Q_BITS;
  assign q_shift = qacc_q >>> Q_BITS;

`ifdef PARK_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

  // Clamp each shifted result into the signed output range
  always_comb begin
    d_res   = d_shift[D_WIDTH-1:0];
    d_clamp = 1'b0;
    q_res   = q_shift[D_WIDTH-1:0];
    q_clamp = 1'b0;
    if (d_shift > SAT_MAX) begin
      d_res   = SAT_MAX[D_WIDTH-1:0];
      d_clamp = 1'b1;
    end else if (d_shift < SAT_MIN) begin
      d_res   = SAT_MIN[D_WIDTH-1:0];
      d_clamp = 1'b1;
    end
    if (q_shift > SAT_MAX) begin
      q_res   = SAT_MAX[D_WIDTH-1:0];
      q_clamp = 1'b1;
    end else if (q_shift < SAT_MIN) begin
      q_res   = SAT_MIN[D_WIDTH-1:0];
      q_clamp = 1'b1;
    end
  end
`else
  // Wrap: keep only the low D_WIDTH bits, upper bits are deliberately dropped
  logic unused_hi_bits;
  assign d_res          = d_shift[D_WIDTH-1:0];
  assign q_res          = q_shift[D_WIDTH-1:0];
  assign d_clamp        = 1'b0;
  assign q_clamp        = 1'b0;
  assign unused_hi_bits = ^{d_shift[ACC_W-1:D_WIDTH], q_shift[ACC_W-1:D_WIDTH]};
`endif

  // Sequencer: latch operands, four multiply-accumulate steps, then publish
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    dacc_d  = dacc_q;
    qacc_d  = qacc_q;
    d_d     = d_q;
    q_d     = q_q;
    done_d  = 1'b0;
    sat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = alpha;
          b_d     = beta;
          s_d     = sin;
          c_d     = cos;
          state_d = M_AC;
        end
      end
      M_AC: begin
        dacc_d  = prod_ext;
        state_d = M_BS;
      end
      M_BS: begin
        dacc_d  = dacc_q + prod_ext;
        state_d = M_BC;
      end
      M_BC: begin
        qacc_d  = prod_ext;
        state_d = M_AS;
      end
      M_AS: begin
        qacc_d  = qacc_q - prod_ext;
        state_d = OUT;
      end
      OUT: begin
        d_d     = d_res;
        q_d     = q_res;
        done_d  = 1'b1;
        sat_d   = d_clamp | q_clamp;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transform in flight
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      dacc_q  <= '0;
      qacc_q  <= '0;
      d_q     <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      dacc_q  <= dacc_d;
      qacc_q  <= qacc_d;
      d_q     <= d_d;
      q_q     <= q_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign d    = d_q;
  assign q    = q_q;
  assign done = done_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_park_transform.sv
// Testbench for park_transform: a 32-bit and a 16-bit instance driven with
// directed and random transforms, checked against a wide-integer reference.
module tb_park_transform;

  localparam int QB = 10;

  int checks = 0;
  int errors = 0;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a32 = '0, b32 = '0, s32 = '0, c32 = '0;
  logic        st32 = 1'b0;
  logic        busy32, done32, sat32;
  logic [31:0] d32, q32;

  logic [15:0] a16 = '0, b16 = '0, s16 = '0, c16 = '0;
  logic        st16 = 1'b0;
  logic        busy16, done16, sat16;
  logic [15:0] d16, q16;

  park_transform #(.D_WIDTH(32), .Q_BITS(QB)) u32 (
    .clk(clk), .rstb(rstb), .alpha(a32), .beta(b32), .sin(s32), .cos(c32),
    .start(st32), .busy(busy32), .d(d32), .q(q32), .done(done32), .sat(sat32)
  );

  park_transform #(.D_WIDTH(16), .Q_BITS(QB)) u16 (
    .clk(clk), .rstb(rstb), .alpha(a16), .beta(b16), .sin(s16), .cos(c16),
    .start(st16), .busy(busy16), .d(d16), .q(q16), .done(done16), .sat(sat16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact products in 128-bit integers, floor shift, then clamp or wrap to w bits
  function automatic void park_ref(input logic signed [63:0] a, input logic signed [63:0] b,
                                   input logic signed [63:0] s, input logic signed [63:0] c,
                                   input int w, output logic [63:0] dm, output logic [63:0] qm,
                                   output logic sm);
    logic signed [127:0] pa, pb, ps, pc, pd, pq, hi, lo, mask;
    pa = a; pb = b; ps = s; pc = c;
    pd = (pa * pc + pb * ps) >>> QB;
    pq = (pb * pc - pa * ps) >>> QB;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    sm = 1'b0;
`ifdef PARK_SAT_EN
    if (pd > hi) begin pd = hi; sm = 1'b1; end
    else if (pd < lo) begin pd = lo; sm = 1'b1; end
    if (pq > hi) begin pq = hi; sm = 1'b1; end
    else if (pq < lo) begin pq = lo; sm = 1'b1; end
`else
    if (hi < lo) sm = 1'b1;
`endif
    mask = (128'sd1 <<< w) - 128'sd1;
    dm = 64'(pd & mask);
    qm = 64'(pq & mask);
  endfunction

  // One full 32-bit transform: accept, scramble inputs, wait for done, check
  task automatic xf32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                      input logic [31:0] c, input string tag);
    logic [63:0] dm, qm;
    logic        sm;
    int          lat;
    park_ref($signed(a), $signed(b), $signed(s), $signed(c), 32, dm, qm, sm);
    a32 = a; b32 = b; s32 = s; c32 = c; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    chk({tag, ".busy_on"}, 64'(busy32), 64'd1);
    a32 = $urandom; b32 = $urandom; s32 = $urandom; c32 = $urandom;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done32) lat = k;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd5);
    chk({tag, ".d"}, 64'(d32), dm);
    chk({tag, ".q"}, 64'(q32), qm);
    chk({tag, ".sat"}, 64'(sat32), 64'(sm));
    chk({tag, ".busy_off"}, 64'(busy32), 64'd0);
    $display("xf32 %s a=%0d b=%0d s=%0d c=%0d -> d=%0d q=%0d sat=%0b lat=%0d",
             tag, $signed(a), $signed(b), $signed(s), $signed(c),
             $signed(d32), $signed(q32), sat32, lat);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(done32), 64'd0);
  endtask

  task automatic xf16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                      input logic [15:0] c, input string tag);
    logic [63:0] dm, qm;
    logic        sm;
    int          lat;
    park_ref($signed(a), $signed(b), $signed(s), $signed(c), 16, dm, qm, sm);
    a16 = a; b16 = b; s16 = s; c16 = c; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); s16 = 16'($urandom); c16 = 16'($urandom);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done16) lat = k;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd5);
    chk({tag, ".d"}, 64'(d16), dm);
    chk({tag, ".q"}, 64'(q16), qm);
    chk({tag, ".sat"}, 64'(sat16), 64'(sm));
    $display("xf16 %s a=%0d b=%0d s=%0d c=%0d -> d=%0d q=%0d sat=%0b lat=%0d",
             tag, $signed(a), $signed(b), $signed(s), $signed(c),
             $signed(d16), $signed(q16), sat16, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] dm, qm;
    logic        sm;
    int          nd;
    logic [31:0] ra, rb, rs, rc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.d", 64'(d32), 64'd0);
    chk("rst.q", 64'(q32), 64'd0);
    chk("rst.done", 64'(done32), 64'd0);
    chk("rst.busy", 64'(busy32), 64'd0);
    chk("rst.sat", 64'(sat32), 64'd0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Identity and quarter-turn
    xf32(32'd1024, 32'd0, 32'd0, 32'd1024, "ident");
    chk("ident.d_lit", 64'(d32), 64'd1024);
    chk("ident.q_lit", 64'(q32), 64'd0);
    xf32(32'd1024, 32'd0, 32'd1024, 32'd0, "rot90");
    chk("rot90.d_lit", 64'(d32), 64'd0);
    chk("rot90.q_lit", 64'(q32), 64'h0000_0000_FFFF_FC00);

    // Floor rounding of a negative sub-LSB result
    xf32(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, "floor");
    chk("floor.d_lit", 64'(d32), 64'h0000_0000_FFFF_FFFF);

    // Start during busy is ignored; inputs changed after accept have no effect
    park_ref(64'sd300, -64'sd200, 64'sd500, 64'sd700, 32, dm, qm, sm);
    a32 = 32'd300; b32 = -32'sd200; s32 = 32'd500; c32 = 32'd700; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    a32 = 32'd9; b32 = 32'd9; s32 = 32'd9; c32 = 32'd9;
    @(posedge clk); #1;
    st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    nd = 0;
    for (int k = 3; k <= 16; k++) begin
      @(posedge clk); #1;
      if (done32) begin
        nd++;
        chk("ign.d", 64'(d32), dm);
        chk("ign.q", 64'(q32), qm);
      end
    end
    chk("ign.done_count", 64'(nd), 64'd1);
    $display("ignore-start test: dones=%0d d=%0d q=%0d", nd, $signed(d32), $signed(q32));

    // Start held high: one result every 6 cycles
    park_ref(64'sd1000, 64'sd2000, 64'sd600, 64'sd800, 32, dm, qm, sm);
    a32 = 32'd1000; b32 = 32'd2000; s32 = 32'd600; c32 = 32'd800; st32 = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (done32) begin
        chk("held.when", 64'(k), 64'(5 + 6 * nd));
        chk("held.d", 64'(d32), dm);
        chk("held.q", 64'(q32), qm);
        nd++;
      end
    end
    st32 = 1'b0;
    chk("held.done_count", 64'(nd), 64'd3);
    $display("held-start test: dones=%0d d=%0d q=%0d", nd, $signed(d32), $signed(q32));
    repeat (2) @(posedge clk);
    #1;

    // Leave a nonzero result, then reset three cycles after accept
    xf32(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, "pre_rst");
    a32 = 32'd5000; b32 = 32'd7000; s32 = 32'd400; c32 = 32'd900; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b0;
    #1;
    chk("mrst.busy", 64'(busy32), 64'd0);
    chk("mrst.d", 64'(d32), 64'd0);
    chk("mrst.q", 64'(q32), 64'd0);
    chk("mrst.done", 64'(done32), 64'd0);
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done32) nd++;
    end
    rstb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done32) nd++;
    end
    chk("mrst.no_done", 64'(nd), 64'd0);
    $display("mid-reset test: spurious dones=%0d", nd);
    xf32(32'd5000, 32'd7000, 32'd400, 32'd900, "post_rst");

    // 16-bit overflow corner: wraps to -128, or clamps to 32767 with sat
    xf16(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, "big16");
`ifdef PARK_SAT_EN
    chk("big16.d_lit", 64'(d16), 64'h7FFF);
    chk("big16.sat_lit", 64'(sat16), 64'd1);
`else
    chk("big16.d_lit", 64'(d16), 64'hFF80);
    chk("big16.sat_lit", 64'(sat16), 64'd0);
`endif
    chk("big16.q_lit", 64'(q16), 64'd0);
    xf16(16'h8000, 16'h8000, 16'h7FFF, 16'h8000, "neg16");

    // Random 32-bit: alternate full-range and Q10-scale operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = $urandom; rc = $urandom;
      if (i % 2 == 1) begin
        ra = {{18{ra[13]}}, ra[13:0]};
        rb = {{18{rb[13]}}, rb[13:0]};
        rs = {{21{rs[10]}}, rs[10:0]};
        rc = {{21{rc[10]}}, rc[10:0]};
      end
      xf32(ra, rb, rs, rc, $sformatf("rnd32_%0d", i));
    end

    // Random 16-bit, frequently overflowing
    for (int i = 0; i < 10; i++) begin
      xf16(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           $sformatf("rnd16_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
